// File: rtl/mdu_controller_pkg.sv
// Shared definitions for the multiply/divide unit: ISA op codes, FSM states, op-class decode.
package mdu_controller_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] SPECIAL_MFHI  = 6'h10;
  localparam logic [OP_W-1:0] SPECIAL_MTHI  = 6'h11;
  localparam logic [OP_W-1:0] SPECIAL_MFLO  = 6'h12;
  localparam logic [OP_W-1:0] SPECIAL_MTLO  = 6'h13;
  localparam logic [OP_W-1:0] SPECIAL_MULT  = 6'h18;
  localparam logic [OP_W-1:0] SPECIAL_MULTU = 6'h19;
  localparam logic [OP_W-1:0] SPECIAL_DIV   = 6'h1A;
  localparam logic [OP_W-1:0] SPECIAL_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mdu_state_e;

  function automatic logic is_long_op(input logic [OP_W-1:0] op);
    return (op == SPECIAL_MULT) || (op == SPECIAL_MULTU) ||
           (op == SPECIAL_DIV)  || (op == SPECIAL_DIVU);
  endfunction

  function automatic logic is_mf_op(input logic [OP_W-1:0] op);
    return (op == SPECIAL_MFHI) || (op == SPECIAL_MFLO);
  endfunction

  function automatic logic is_mt_op(input logic [OP_W-1:0] op);
    return (op == SPECIAL_MTHI) || (op == SPECIAL_MTLO);
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return (op == SPECIAL_MULT) || (op == SPECIAL_DIV);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == SPECIAL_DIV) || (op == SPECIAL_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring divide step.
module mdu_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
    rem_sh = {acc, q[WIDTH-1]};
    // Partial remainder stays below the divisor, so bit WIDTH of diff is a clean borrow
    diff   = rem_sh - {1'b0, b};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_nxt = diff[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_controller.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; stalls the pipeline on in-flight hazards.
module mdu_controller
  import mdu_controller_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             w_clock,
  input  logic             w_reset_n,
  input  logic             w_valid_in,
  input  logic [OP_W-1:0]  w_op_code_6,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  input  logic             w_flush,
  output logic             w_ready_out,
  output logic             w_stall_out,
  output logic             w_busy_out,
  output logic [WIDTH-1:0] w_output_x,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);

  mdu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] hi, hi_nxt, lo, lo_nxt;
  logic [WIDTH-1:0] acc, acc_nxt, q, q_nxt;
  logic [WIDTH-1:0] opb, opb_nxt, raw_a, raw_a_nxt;
  logic             is_div, is_div_nxt, neg_q, neg_q_nxt, neg_r, neg_r_nxt, dz, dz_nxt;

  logic             long_op, mf_op, mt_op, sgn_op, div_op;
  logic [WIDTH-1:0] abs_a, abs_b, step_acc, step_q;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign long_op = w_valid_in & is_long_op(w_op_code_6);
  assign mf_op   = w_valid_in & is_mf_op(w_op_code_6);
  assign mt_op   = w_valid_in & is_mt_op(w_op_code_6);
  assign sgn_op  = is_signed_op(w_op_code_6);
  assign div_op  = is_div_op(w_op_code_6);

  assign abs_a = (sgn_op & w_input1_x[WIDTH-1]) ? -w_input1_x : w_input1_x;
  assign abs_b = (sgn_op & w_input2_x[WIDTH-1]) ? -w_input2_x : w_input2_x;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .q       (q),
    .b       (opb),
    .acc_nxt (step_acc),
    .q_nxt   (step_q)
  );

  // Sign fix-up applied when the result is committed
  assign prod     = {acc, q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -q : q;
  assign rem_fix  = neg_r ? -acc : acc;

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      q      <= '0;
      opb    <= '0;
      raw_a  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      acc    <= acc_nxt;
      q      <= q_nxt;
      opb    <= opb_nxt;
      raw_a  <= raw_a_nxt;
      is_div <= is_div_nxt;
      neg_q  <= neg_q_nxt;
      neg_r  <= neg_r_nxt;
      dz     <= dz_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hi_nxt     = hi;
    lo_nxt     = lo;
    acc_nxt    = acc;
    q_nxt      = q;
    opb_nxt    = opb;
    raw_a_nxt  = raw_a;
    is_div_nxt = is_div;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    dz_nxt     = dz;
    case (state)
      ST_IDLE: begin
        if (!w_flush) begin
          if (long_op) begin
            state_nxt  = ST_RUN;
            cnt_nxt    = CNT_W'(WIDTH - 1);
            acc_nxt    = '0;
            is_div_nxt = div_op;
            dz_nxt     = div_op & (w_input2_x == '0);
            raw_a_nxt  = w_input1_x;
            neg_q_nxt  = sgn_op & (w_input1_x[WIDTH-1] ^ w_input2_x[WIDTH-1]);
            neg_r_nxt  = sgn_op & w_input1_x[WIDTH-1];
            // Divide iterates over the dividend; multiply shifts out the multiplier
            q_nxt      = div_op ? abs_a : abs_b;
            opb_nxt    = div_op ? abs_b : abs_a;
          end else if (mt_op) begin
            if (w_op_code_6 == SPECIAL_MTHI) hi_nxt = w_input1_x;
            else                             lo_nxt = w_input1_x;
          end
        end
      end
      ST_RUN: begin
        if (w_flush) begin
          state_nxt = ST_IDLE;
        end else begin
          acc_nxt = step_acc;
          q_nxt   = step_q;
          if (cnt == '0) state_nxt = ST_FIN;
          else           cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
        if (!w_flush) begin
          if (!is_div) begin
            hi_nxt = prod_fix[2*WIDTH-1:WIDTH];
            lo_nxt = prod_fix[WIDTH-1:0];
          end else if (dz) begin
            hi_nxt = raw_a;
            lo_nxt = '1;
          end else begin
            hi_nxt = rem_fix;
            lo_nxt = quo_fix;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign w_ready_out = (state == ST_IDLE);
  assign w_busy_out  = (state != ST_IDLE);
  assign w_stall_out = (mf_op | long_op | mt_op) & (state != ST_IDLE);
  assign w_output_x  = (mf_op && state == ST_IDLE) ?
                       ((w_op_code_6 == SPECIAL_MFHI) ? hi : lo) : '0;
  assign w_hi_x      = hi;
  assign w_lo_x      = lo;

endmodule

// File: tb/tb_mdu_controller.sv
// Directed bench for mdu_controller with a scoreboard of expected HI/LO results.
module tb_mdu_controller;
  import mdu_controller_pkg::*;

  logic        w_clock = 1'b0;
  logic        w_reset_n = 1'b0;
  logic        w_valid_in = 1'b0;
  logic [5:0]  w_op_code_6 = 6'h0;
  logic [31:0] w_input1_x = 32'h0;
  logic [31:0] w_input2_x = 32'h0;
  logic        w_flush = 1'b0;
  logic        w_ready_out, w_stall_out, w_busy_out;
  logic [31:0] w_output_x, w_hi_x, w_lo_x;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb_q[$];

  always #5 w_clock = ~w_clock;

  mdu_controller #(.WIDTH(32), .CNT_W(6)) dut (
    .w_clock     (w_clock),
    .w_reset_n   (w_reset_n),
    .w_valid_in  (w_valid_in),
    .w_op_code_6 (w_op_code_6),
    .w_input1_x  (w_input1_x),
    .w_input2_x  (w_input2_x),
    .w_flush     (w_flush),
    .w_ready_out (w_ready_out),
    .w_stall_out (w_stall_out),
    .w_busy_out  (w_busy_out),
    .w_output_x  (w_output_x),
    .w_hi_x      (w_hi_x),
    .w_lo_x      (w_lo_x)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge w_clock);
    #1;
  endtask

  task automatic sample();
    @(negedge w_clock);
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    w_valid_in  = v;
    w_op_code_6 = op;
    w_input1_x  = a;
    w_input2_x  = b;
  endtask

  function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb;
    logic [63:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    qa = a;
    qb = b;
    r = 64'h0;
    case (op)
      SPECIAL_MULT:  r = sa * sb;
      SPECIAL_MULTU: r = {32'h0, a} * {32'h0, b};
      SPECIAL_DIV: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {32'(qa % qb), 32'(qa / qb)};
      end
      SPECIAL_DIVU: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  // Issue one long op, wait for completion, then compare against the scoreboard head
  task automatic run_long(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
    int n;
    logic [63:0] e;
    sb_q.push_back(exp);
    drive(1'b1, op, a, b);
    step();
    drive(1'b0, 6'h0, 32'h0, 32'h0);
    n = 0;
    sample();
    while (!w_ready_out && n < 60) begin
      step();
      sample();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    e = sb_q.pop_front();
    check(tag, {w_hi_x, w_lo_x}, e);
    step();
  endtask

  initial begin
    int n;
    int busy_cnt;
    int stall_cnt;
    logic [63:0] e;
    logic [5:0] ops [4];
    logic [31:0] ra, rb;
    ops[0] = SPECIAL_MULT;
    ops[1] = SPECIAL_MULTU;
    ops[2] = SPECIAL_DIV;
    ops[3] = SPECIAL_DIVU;

    // Reset state
    step();
    step();
    sample();
    check("rst_ready", 64'(w_ready_out), 64'd1);
    check("rst_busy", 64'(w_busy_out), 64'd0);
    check("rst_stall", 64'(w_stall_out), 64'd0);
    check("rst_out", 64'(w_output_x), 64'd0);
    check("rst_hilo", {w_hi_x, w_lo_x}, 64'd0);
    step();
    w_reset_n = 1'b1;
    step();

    // Reset mid-RUN aborts and clears HI/LO
    drive(1'b1, SPECIAL_MTHI, 32'h1111_2222, 32'h0);
    step();
    drive(1'b1, SPECIAL_MULTU, 32'd5, 32'd6);
    step();
    drive(1'b0, 6'h0, 32'h0, 32'h0);
    repeat (9) step();
    check("pre_rst_hi", 64'(w_hi_x), 64'h1111_2222);
    w_reset_n = 1'b0;
    #1;
    check("midrst_ready", 64'(w_ready_out), 64'd1);
    check("midrst_hilo", {w_hi_x, w_lo_x}, 64'd0);
    step();
    w_reset_n = 1'b1;
    repeat (40) step();
    sample();
    check("midrst_nowb", {w_hi_x, w_lo_x}, 64'd0);
    check("midrst_busy", 64'(w_busy_out), 64'd0);
    step();

    // MULT with an MFHI waiting behind it
    sb_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    drive(1'b1, SPECIAL_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    step();
    drive(1'b0, 6'h0, 32'h0, 32'h0);
    busy_cnt = 0;
    stall_cnt = 0;
    sample();
    if (w_busy_out) busy_cnt++;
    step();
    drive(1'b1, SPECIAL_MFHI, 32'h0, 32'h0);
    for (int i = 0; i < 60; i++) begin
      sample();
      if (w_busy_out) busy_cnt++;
      if (!w_stall_out) break;
      stall_cnt++;
      step();
    end
    check("mult_busy_cycles", 64'(busy_cnt), 64'd33);
    check("mfhi_stall_cycles", 64'(stall_cnt), 64'd32);
    check("mfhi_out", 64'(w_output_x), 64'hFFFF_FFFF);
    e = sb_q.pop_front();
    check("mult_hilo", {w_hi_x, w_lo_x}, e);
    step();
    drive(1'b0, 6'h0, 32'h0, 32'h0);

    // Division cases
    run_long("div_neg", SPECIAL_DIV, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_long("divu_7_2", SPECIAL_DIVU, 32'd7, 32'd2, {32'd1, 32'd3});
    run_long("divu_by0", SPECIAL_DIVU, 32'h1234, 32'h0, {32'h1234, 32'hFFFF_FFFF});
    run_long("div_ovf", SPECIAL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});

    // MTHI in IDLE, then a flushed MULTU leaves HI/LO alone
    drive(1'b1, SPECIAL_MTHI, 32'hA5A5_A5A5, 32'h0);
    sample();
    check("mthi_stall", 64'(w_stall_out), 64'd0);
    step();
    drive(1'b0, 6'h0, 32'h0, 32'h0);
    sample();
    check("mthi_hi", 64'(w_hi_x), 64'hA5A5_A5A5);
    step();
    drive(1'b1, SPECIAL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 6'h0, 32'h0, 32'h0);
    repeat (19) step();
    w_flush = 1'b1;
    step();
    w_flush = 1'b0;
    sample();
    check("flush_ready", 64'(w_ready_out), 64'd1);
    check("flush_hilo", {w_hi_x, w_lo_x}, {32'hA5A5_A5A5, 32'h8000_0000});
    repeat (40) step();
    sample();
    check("flush_nowb", {w_hi_x, w_lo_x}, {32'hA5A5_A5A5, 32'h8000_0000});
    step();

    // Flush in IDLE suppresses mt write and acceptance; unknown op ignored
    drive(1'b1, SPECIAL_MTLO, 32'hDEAD_BEEF, 32'h0);
    w_flush = 1'b1;
    step();
    drive(1'b1, SPECIAL_MULT, 32'd3, 32'd3);
    sample();
    check("idleflush_mtlo", 64'(w_lo_x), 64'h8000_0000);
    step();
    w_flush = 1'b0;
    drive(1'b1, 6'h20, 32'h1, 32'h1);
    sample();
    check("idleflush_busy", 64'(w_busy_out), 64'd0);
    check("badop_stall", 64'(w_stall_out), 64'd0);
    check("badop_out", 64'(w_output_x), 64'd0);
    step();
    drive(1'b1, SPECIAL_MFLO, 32'h0, 32'h0);
    sample();
    check("badop_busy", 64'(w_busy_out), 64'd0);
    check("mflo_out", 64'(w_output_x), 64'h8000_0000);
    step();
    drive(1'b0, 6'h0, 32'h0, 32'h0);

    // Back-to-back: second MULTU stalls until IDLE, accepted one edge later
    sb_q.push_back(64'd15);
    sb_q.push_back(64'hFFFF_FFFE_0000_0001);
    drive(1'b1, SPECIAL_MULTU, 32'd3, 32'd5);
    step();
    drive(1'b1, SPECIAL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    sample();
    while (w_stall_out && n < 60) begin
      step();
      sample();
      n++;
    end
    check("b2b_stall_cycles", 64'(n), 64'd33);
    check("b2b_ready", 64'(w_ready_out), 64'd1);
    e = sb_q.pop_front();
    check("b2b_first", {w_hi_x, w_lo_x}, e);
    step();
    drive(1'b0, 6'h0, 32'h0, 32'h0);
    n = 0;
    sample();
    check("b2b_accept", 64'(w_busy_out), 64'd1);
    while (!w_ready_out && n < 60) begin
      step();
      sample();
      n++;
    end
    check("b2b_latency", 64'(n), 64'd33);
    e = sb_q.pop_front();
    check("b2b_second", {w_hi_x, w_lo_x}, e);
    step();

    // Random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 5) rb = 32'(rb[7:0]);
      if (i == 6) ra = {1'b1, ra[30:0]};
      run_long("rand", ops[i % 4], ra, rb, model(ops[i % 4], ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
